// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
// perceptron_pkg
// Shared widths, FSM encoding and saturation limits for the perceptron path.
// Revision: 1.0
// ============================================================================
package perceptron_pkg;

    localparam int X_W = 4;
    localparam int W_W = 4;
    localparam int B_W = 6;

    localparam int W_MAX = (1 << (W_W - 1)) - 1;
    localparam int W_MIN = -(1 << (W_W - 1));
    localparam int B_MAX = (1 << (B_W - 1)) - 1;
    localparam int B_MIN = -(1 << (B_W - 1));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/perceptron_sat_update.sv
`default_nettype none
// ============================================================================
// perceptron_sat_update
// Combinational saturating accumulate: o_val = sat(i_val + i_err * i_x).
// Revision: 1.0
// ============================================================================
module perceptron_sat_update #(
    parameter int WIDTH   = 4,
    parameter int X_WIDTH = 4
) (
    input  logic signed [WIDTH-1:0]   i_val,
    input  logic signed [1:0]         i_err,
    input  logic signed [X_WIDTH-1:0] i_x,
    output logic signed [WIDTH-1:0]   o_val
);

    // Two guard bits cover both the negation of the most negative x and the carry.
    localparam int SW = ((WIDTH > X_WIDTH) ? WIDTH : X_WIDTH) + 2;
    localparam logic signed [SW-1:0] c_MAX = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] c_MIN = SW'(-(2 ** (WIDTH - 1)));

    logic signed [SW-1:0] w_val_ext;
    logic signed [SW-1:0] w_x_ext;
    logic signed [SW-1:0] w_delta;
    logic signed [SW-1:0] w_sum;

    assign w_val_ext = {{(SW - WIDTH){i_val[WIDTH-1]}}, i_val};
    assign w_x_ext   = {{(SW - X_WIDTH){i_x[X_WIDTH-1]}}, i_x};

    always_comb begin
        w_delta = '0;
        case (i_err)
            2'b01:   w_delta = w_x_ext;
            2'b11:   w_delta = -w_x_ext;
            default: w_delta = '0;
        endcase
        w_sum = w_val_ext + w_delta;
        if (w_sum > c_MAX) begin
            o_val = c_MAX[WIDTH-1:0];
        end else if (w_sum < c_MIN) begin
            o_val = c_MIN[WIDTH-1:0];
        end else begin
            o_val = w_sum[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// perceptron_trainer
// Online perceptron learning engine: sample handshake, error capture, saturating
// weight/bias update, epoch counting with convergence and stall detection.
// Revision: 1.0
// ============================================================================
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter logic signed [W_W-1:0] W1_INIT    = '0,
    parameter logic signed [W_W-1:0] W2_INIT    = '0,
    parameter logic signed [B_W-1:0] BIAS_INIT  = '0,
    parameter int unsigned           EPOCH_LEN  = 4,
    parameter int unsigned           MAX_EPOCHS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  train_en,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [X_W-1:0] s_x1,
    input  logic signed [X_W-1:0] s_x2,
    input  logic                  s_target,
    output logic signed [X_W-1:0] p_x1,
    output logic signed [X_W-1:0] p_x2,
    output logic signed [W_W-1:0] w1,
    output logic signed [W_W-1:0] w2,
    output logic signed [B_W-1:0] bias,
    input  logic                  p_out,
    output logic                  upd_valid,
    output logic signed [1:0]     upd_err,
    output logic [7:0]            epoch,
    output logic                  converged,
    output logic                  stalled
);

    localparam int CNT_W = (EPOCH_LEN < 2) ? 1 : $clog2(EPOCH_LEN);
    localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(EPOCH_LEN - 1);
    localparam logic [8:0]       c_MAX_EP = 9'(MAX_EPOCHS);
    localparam logic signed [1:0] c_ONE   = 2'sb01;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_target;
    logic signed [1:0]       r_err;
    logic [CNT_W-1:0]        r_sample_cnt;
    logic [CNT_W-1:0]        r_epoch_errs;
    logic signed [W_W-1:0]   w_w1_nxt;
    logic signed [W_W-1:0]   w_w2_nxt;
    logic signed [B_W-1:0]   w_bias_nxt;
    logic                    w_upd_en;
    logic                    w_err_nz;
    logic                    w_last;
    logic [8:0]              w_epoch_inc;

    perceptron_sat_update #(.WIDTH(W_W), .X_WIDTH(X_W)) u_upd_w1 (
        .i_val (w1),   .i_err (r_err), .i_x (p_x1),  .o_val (w_w1_nxt)
    );
    perceptron_sat_update #(.WIDTH(W_W), .X_WIDTH(X_W)) u_upd_w2 (
        .i_val (w2),   .i_err (r_err), .i_x (p_x2),  .o_val (w_w2_nxt)
    );
    perceptron_sat_update #(.WIDTH(B_W), .X_WIDTH(2)) u_upd_bias (
        .i_val (bias), .i_err (r_err), .i_x (c_ONE), .o_val (w_bias_nxt)
    );

    assign w_upd_en    = train_en & ~converged & ~stalled;
    assign w_err_nz    = (r_err != 2'sb00);
    assign w_last      = (r_sample_cnt == c_LAST);
    assign w_epoch_inc = {1'b0, epoch} + 9'd1;

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) w_state_nxt = EVAL;
            end
            EVAL:    w_state_nxt = UPDATE;
            UPDATE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_target     <= 1'b0;
            r_err        <= 2'sb00;
            r_sample_cnt <= '0;
            r_epoch_errs <= '0;
            p_x1         <= '0;
            p_x2         <= '0;
            w1           <= W1_INIT;
            w2           <= W2_INIT;
            bias         <= BIAS_INIT;
            upd_valid    <= 1'b0;
            upd_err      <= 2'sb00;
            epoch        <= '0;
            converged    <= 1'b0;
            stalled      <= 1'b0;
        end else if (clear) begin
            // Clear wins over a same-cycle handshake: the offered sample is dropped.
            r_state      <= IDLE;
            r_target     <= 1'b0;
            r_err        <= 2'sb00;
            r_sample_cnt <= '0;
            r_epoch_errs <= '0;
            p_x1         <= '0;
            p_x2         <= '0;
            w1           <= W1_INIT;
            w2           <= W2_INIT;
            bias         <= BIAS_INIT;
            upd_valid    <= 1'b0;
            upd_err      <= 2'sb00;
            epoch        <= '0;
            converged    <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            upd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        p_x1     <= s_x1;
                        p_x2     <= s_x2;
                        r_target <= s_target;
                    end
                end
                EVAL: begin
                    r_err <= $signed({1'b0, r_target}) - $signed({1'b0, p_out});
                end
                UPDATE: begin
                    upd_valid <= 1'b1;
                    upd_err   <= r_err;
                    if (w_upd_en) begin
                        w1   <= w_w1_nxt;
                        w2   <= w_w2_nxt;
                        bias <= w_bias_nxt;
                    end
                    if (w_last) begin
                        r_sample_cnt <= '0;
                        r_epoch_errs <= '0;
                        if (epoch != 8'hFF) epoch <= epoch + 8'd1;
                        if (r_epoch_errs == '0 && !w_err_nz) begin
                            converged <= 1'b1;
                        end else if (!converged && w_epoch_inc == c_MAX_EP) begin
                            stalled <= 1'b1;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                        if (w_err_nz) r_epoch_errs <= r_epoch_errs + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
